// File: rtl/nibble_pkg.sv
// nibble_pkg: shared types and widths for the nibble serializer and assembler
package nibble_pkg;
  localparam int BYTE_W = 8;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {EMPTY, FIRST, SECOND} ser_state_e;
endpackage

// File: rtl/byte_nibble_serializer.sv
// byte_nibble_serializer: splits each val/rdy byte into two val/rdy nibbles, LO_FIRST picks order
module byte_nibble_serializer
  import nibble_pkg::*;
#(
  parameter bit LO_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_val,
  output logic                in_rdy,
  input  logic [BYTE_W-1:0]   in_msg,
  output logic                out_val,
  input  logic                out_rdy,
  output logic [NIBBLE_W-1:0] out_msg,
  output logic                out_last
);
  ser_state_e state, state_nx;
  logic [BYTE_W-1:0] data;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= EMPTY;
      data <= '0;
    end else begin
      state <= state_nx;
      if (in_val && in_rdy) data <= in_msg;
    end
  end
  always_comb begin
    in_rdy = (state == EMPTY) || (state == SECOND && out_rdy);
    out_val = state != EMPTY;
    out_last = state == SECOND;
    out_msg = (state == EMPTY) ? '0 :
              (((state == FIRST) == LO_FIRST) ? data[3:0] : data[7:4]);
    state_nx = (state == EMPTY) ? (in_val ? FIRST : EMPTY) :
               (state == FIRST) ? (out_rdy ? SECOND : FIRST) :
               (out_rdy ? (in_val ? FIRST : EMPTY) : SECOND);
  end
endmodule

// File: tb/tb_byte_nibble_serializer.sv
// tb_byte_nibble_serializer: random and directed checks of both nibble orders against a queue model
module tb_byte_nibble_serializer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_val = 1'b1;
  logic [7:0] in_msg = 8'h77;
  logic out_rdy = 1'b0;
  logic in_rdy1, out_val1, out_last1, in_rdy0, out_val0, out_last0;
  logic [3:0] out_msg1, out_msg0;
  int errors = 0;
  int checks = 0;
  bit init = 1'b0;
  logic [3:0] q1[$];
  logic [3:0] q0[$];
  always #5 clk = ~clk;
  byte_nibble_serializer #(.LO_FIRST(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_val(in_val), .in_rdy(in_rdy1), .in_msg(in_msg),
    .out_val(out_val1), .out_rdy(out_rdy), .out_msg(out_msg1), .out_last(out_last1)
  );
  byte_nibble_serializer #(.LO_FIRST(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .in_val(in_val), .in_rdy(in_rdy0), .in_msg(in_msg),
    .out_val(out_val0), .out_rdy(out_rdy), .out_msg(out_msg0), .out_last(out_last0)
  );
  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", n, a, e, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    bit rdy, ofire;
    rdy = (q1.size() == 0) || (q1.size() == 1 && out_rdy);
    if (init) begin
      chk("m_val1", {7'd0, out_val1}, {7'd0, q1.size() > 0});
      chk("m_last1", {7'd0, out_last1}, {7'd0, q1.size() == 1});
      chk("m_msg1", {4'd0, out_msg1}, {4'd0, q1.size() > 0 ? q1[0] : 4'd0});
      chk("m_rdy1", {7'd0, in_rdy1}, {7'd0, rdy});
      chk("m_val0", {7'd0, out_val0}, {7'd0, q0.size() > 0});
      chk("m_last0", {7'd0, out_last0}, {7'd0, q0.size() == 1});
      chk("m_msg0", {4'd0, out_msg0}, {4'd0, q0.size() > 0 ? q0[0] : 4'd0});
      chk("m_rdy0", {7'd0, in_rdy0}, {7'd0, rdy});
    end
    if (!reset_n) begin
      q1.delete();
      q0.delete();
      init = 1'b1;
    end else begin
      ofire = (q1.size() > 0) && out_rdy;
      if (ofire) begin
        void'(q1.pop_front());
        void'(q0.pop_front());
      end
      if (in_val && rdy) begin
        q1.push_back(in_msg[3:0]);
        q1.push_back(in_msg[7:4]);
        q0.push_back(in_msg[7:4]);
        q0.push_back(in_msg[3:0]);
      end
    end
  end
  initial begin
    logic [7:0] bytes[3];
    bit acc;
    bytes = '{8'h12, 8'h34, 8'h56};
    tick;
    tick;
    chk("rst_rdy", {7'd0, in_rdy1}, 8'd1);
    chk("rst_val", {7'd0, out_val1}, 8'd0);
    chk("rst_msg", {4'd0, out_msg1}, 8'd0);
    reset_n = 1'b1;
    in_val = 1'b0;
    tick;
    chk("rst_nocap", {7'd0, out_val1}, 8'd0);
    out_rdy = 1'b1;
    in_val = 1'b1;
    in_msg = 8'hA5;
    tick;
    in_val = 1'b0;
    chk("a5_n0", {3'd0, out_last1, out_msg1}, 8'h05);
    chk("a5_lo0_n0", {3'd0, out_last0, out_msg0}, 8'h0A);
    tick;
    chk("a5_n1", {3'd0, out_last1, out_msg1}, 8'h1A);
    chk("a5_lo0_n1", {3'd0, out_last0, out_msg0}, 8'h15);
    tick;
    chk("a5_done", {7'd0, out_val1}, 8'd0);
    in_val = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_msg = bytes[i];
      tick;
      chk("b2b_lo", {out_val1, in_rdy1, 2'd0, out_msg1}, {2'b10, 2'd0, bytes[i][3:0]});
      tick;
      chk("b2b_hi", {out_val1, in_rdy1, 2'd0, out_msg1}, {2'b11, 2'd0, bytes[i][7:4]});
    end
    in_val = 1'b0;
    tick;
    chk("b2b_done", {7'd0, out_val1}, 8'd0);
    in_val = 1'b1;
    in_msg = 8'hC3;
    tick;
    in_val = 1'b0;
    out_rdy = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {out_val1, in_rdy1, 2'd0, out_msg1}, 8'h83);
      tick;
    end
    out_rdy = 1'b1;
    #1;
    chk("bp_rel0", {4'd0, out_msg1}, 8'h03);
    tick;
    chk("bp_rel1", {3'd0, out_last1, out_msg1}, 8'h1C);
    tick;
    in_val = 1'b1;
    in_msg = 8'hF0;
    tick;
    in_val = 1'b0;
    chk("mid_n0", {4'd0, out_msg1}, 8'h00);
    tick;
    out_rdy = 1'b0;
    reset_n = 1'b0;
    tick;
    chk("mid_rst1", {7'd0, out_val1}, 8'd0);
    chk("mid_rst0", {7'd0, out_val0}, 8'd0);
    reset_n = 1'b1;
    tick;
    chk("mid_after", {7'd0, out_val1}, 8'd0);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = in_val && in_rdy1;
      @(posedge clk);
      #1;
      reset_n = ($urandom_range(0, 199) != 0);
      out_rdy = ($urandom_range(0, 3) != 0);
      if (!(in_val && !acc) || !reset_n) begin
        in_val = ($urandom_range(0, 2) != 0);
        in_msg = 8'($urandom);
      end
    end
    tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
